mem_stage_sram: RTL and testbench

- MEM stage placed directly downstream of the EXE pipeline register. It consumes WB/MEM enables, the ALU result used as the address, the store value and the destination register.
- It performs 32-bit loads and stores to an external 16-bit asynchronous SRAM as two halfword accesses with fixed wait states.
- It stalls the pipeline through `ready` while an access is in flight.
- It contains the MEM/WB pipeline register, which feeds the WB stage and the forwarding unit.

---
 rtl/mem_stage_sram_pkg.sv | 16 +
 rtl/mem_stage_sram_sram_ctrl.sv | 157 +++++++++++++++
 rtl/mem_stage_sram.sv | 91 +++++++++
 tb/tb_mem_stage_sram.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_pkg.sv
// Shared types and default constants for the MEM stage and its SRAM controller.
package mem_stage_sram_pkg;

    localparam int unsigned BASE_ADDR_DEF   = 1024;
    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned SRAM_AW_DEF     = 18;

    // Access sequencer: idle, low halfword, high halfword, completion
    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StDone
    } sram_state_e;

endpackage

// File: rtl/mem_stage_sram_sram_ctrl.sv
// SRAM access sequencer: splits a 32-bit access into two halfword phases with fixed
// wait states, drives registered SRAM pins, assembles load data and produces ready.
// Optional macro MEM_ADDR_CHECK_EN: bad addresses skip the SRAM phases and flag mem_err_o.
module sram_ctrl
    import mem_stage_sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rd_req_i,
    input  logic               wr_req_i,
    input  logic [SRAM_AW-2:0] word_addr_i,
    input  logic [31:0]        wr_data_i,
`ifdef MEM_ADDR_CHECK_EN
    input  logic               addr_err_i,
    output logic               mem_err_o,
`endif
    output logic               ready_o,
    output logic [31:0]        rd_data_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe_o,
    output logic               sram_we_n_o
);

    localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES);

    sram_state_e        state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [31:0]        rdata_q;
    logic [SRAM_AW-1:0] addr_d;
    logic [15:0]        dq_d;
    logic               oe_d, we_n_d;
    logic               req, is_load, last;

    assign req     = rd_req_i | wr_req_i;
    // A store wins when both enables are set
    assign is_load = rd_req_i & ~wr_req_i;
    assign last    = (cnt_q == CntLast);

    // Next-state, phase counter and ready decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_o = ~req;
                if (req) begin
                    cnt_d   = '0;
                    state_d = StLo;
`ifdef MEM_ADDR_CHECK_EN
                    if (addr_err_i) begin
                        state_d = StDone;
                    end
`endif
                end
            end
            StLo: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = StHi;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHi: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                ready_o = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // SRAM pin values for the coming cycle, derived from the next state so pins track phases
    always_comb begin
        addr_d = '0;
        dq_d   = '0;
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if (state_d == StLo || state_d == StHi) begin
            addr_d = {word_addr_i, (state_d == StHi)};
            if (wr_req_i) begin
                dq_d   = (state_d == StHi) ? wr_data_i[31:16] : wr_data_i[15:0];
                oe_d   = 1'b1;
                we_n_d = 1'b0;
            end
        end
    end

    // State, counter and registered SRAM pins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sram_addr_o  <= '0;
            sram_dq_o    <= '0;
            sram_dq_oe_o <= 1'b0;
            sram_we_n_o  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sram_addr_o  <= addr_d;
            sram_dq_o    <= dq_d;
            sram_dq_oe_o <= oe_d;
            sram_we_n_o  <= we_n_d;
        end
    end

    // Load data assembly: sample each half on the last cycle of its phase
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (is_load) begin
            if (state_q == StLo && last) begin
                rdata_q[15:0] <= sram_dq_i;
            end else if (state_q == StHi && last) begin
                rdata_q[31:16] <= sram_dq_i;
            end
`ifdef MEM_ADDR_CHECK_EN
            else if (state_q == StIdle && addr_err_i) begin
                rdata_q <= '0;
            end
`endif
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic err_q;

    // Error flag is high only in the DONE cycle of a rejected access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == StIdle) && req && addr_err_i;
        end
    end

    assign mem_err_o = err_q;
`endif

    assign rd_data_o = rdata_q;

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage: address translation, SRAM access via sram_ctrl, and the MEM/WB register.
// Optional macro MEM_ADDR_CHECK_EN adds the mem_err output and address validation.
module mem_stage_sram
    import mem_stage_sram_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_EN_IN,
    input  logic               MEM_R_EN_IN,
    input  logic               MEM_W_EN_IN,
    input  logic [31:0]        ALU_result_IN,
    input  logic [31:0]        ST_val_IN,
    input  logic [3:0]         Dest_IN,
    output logic               ready,
    output logic               WB_EN,
    output logic               MEM_R_EN,
    output logic [31:0]        ALU_result,
    output logic [31:0]        Mem_read_value,
    output logic [3:0]         Dest,
`ifdef MEM_ADDR_CHECK_EN
    output logic               mem_err,
`endif
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_O,
    input  logic [15:0]        SRAM_DQ_I,
    output logic               SRAM_DQ_OE,
    output logic               SRAM_WE_N
);

    logic [31:0]        addr_off;
    logic [SRAM_AW-2:0] word_addr;
    logic [31:0]        rd_data;
    logic               unused_addr_bits;

    // Byte offset from the SRAM base, reduced to a word index
    assign addr_off         = ALU_result_IN - BASE_ADDR;
    assign word_addr        = addr_off[SRAM_AW:2];
    assign unused_addr_bits = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};

`ifdef MEM_ADDR_CHECK_EN
    logic addr_err;
    assign addr_err = (ALU_result_IN < BASE_ADDR) || (ALU_result_IN[1:0] != 2'b00);
`endif

    sram_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .SRAM_AW     (SRAM_AW)
    ) u_ctrl (
        .clk_i        (clk),
        .rst_ni       (rst),
        .rd_req_i     (MEM_R_EN_IN),
        .wr_req_i     (MEM_W_EN_IN),
        .word_addr_i  (word_addr),
        .wr_data_i    (ST_val_IN),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err_i   (addr_err),
        .mem_err_o    (mem_err),
`endif
        .ready_o      (ready),
        .rd_data_o    (rd_data),
        .sram_addr_o  (SRAM_ADDR),
        .sram_dq_o    (SRAM_DQ_O),
        .sram_dq_i    (SRAM_DQ_I),
        .sram_dq_oe_o (SRAM_DQ_OE),
        .sram_we_n_o  (SRAM_WE_N)
    );

    // MEM/WB register: capture when the stage advances, insert a bubble while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN          <= 1'b0;
            MEM_R_EN       <= 1'b0;
            ALU_result     <= '0;
            Mem_read_value <= '0;
            Dest           <= '0;
        end else if (ready) begin
            WB_EN          <= WB_EN_IN;
            MEM_R_EN       <= MEM_R_EN_IN;
            ALU_result     <= ALU_result_IN;
            Mem_read_value <= rd_data;
            Dest           <= Dest_IN;
        end else begin
            WB_EN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Self-checking bench for mem_stage_sram: an access-level model predicts ready, the MEM/WB
// outputs and the SRAM pins each cycle; literal checks pin the model to known results.
module tb_mem_stage_sram;
    import mem_stage_sram_pkg::*;

    localparam int Base    = 1024;
    localparam int Phase   = 3;              // WAIT_CYCLES + 1
    localparam int DonePos = 2 * Phase + 1;
    localparam int AccLen  = DonePos + 1;    // cycles from request to capture

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
    logic [31:0] ALU_result_IN, ST_val_IN;
    logic [3:0]  Dest_IN;
    logic        ready, WB_EN, MEM_R_EN;
    logic [31:0] ALU_result, Mem_read_value;
    logic [3:0]  Dest;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_O, SRAM_DQ_I;
    logic        SRAM_DQ_OE, SRAM_WE_N;
`ifdef MEM_ADDR_CHECK_EN
    logic        mem_err;
`endif

    mem_stage_sram u_dut (
        .clk            (clk),
        .rst            (rst),
        .WB_EN_IN       (WB_EN_IN),
        .MEM_R_EN_IN    (MEM_R_EN_IN),
        .MEM_W_EN_IN    (MEM_W_EN_IN),
        .ALU_result_IN  (ALU_result_IN),
        .ST_val_IN      (ST_val_IN),
        .Dest_IN        (Dest_IN),
        .ready          (ready),
        .WB_EN          (WB_EN),
        .MEM_R_EN       (MEM_R_EN),
        .ALU_result     (ALU_result),
        .Mem_read_value (Mem_read_value),
        .Dest           (Dest),
`ifdef MEM_ADDR_CHECK_EN
        .mem_err        (mem_err),
`endif
        .SRAM_ADDR      (SRAM_ADDR),
        .SRAM_DQ_O      (SRAM_DQ_O),
        .SRAM_DQ_I      (SRAM_DQ_I),
        .SRAM_DQ_OE     (SRAM_DQ_OE),
        .SRAM_WE_N      (SRAM_WE_N)
    );

    always #5 clk = ~clk;

    // Environment SRAM (written by the DUT) and the model's own memory image
    logic [15:0] sram    [0:1023];
    logic [15:0] ref_mem [0:1023];
    assign SRAM_DQ_I = sram[SRAM_ADDR[9:0]];

    int n_vec = 0;
    int n_err = 0;
    int low_cnt;

    // Model state: position within an access (0 = idle), MEM/WB image, last load word
    int          m_pos;
    logic        m_bad;
    logic        m_wb, m_mr;
    logic [31:0] m_alu, m_mrv, m_rdata;
    logic [3:0]  m_dest;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
        return (a < Base) || (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - Base) >> 2;
        return int'(off & 32'h1FFFF);
    endfunction

    function automatic logic model_ready();
        logic req;
        req = MEM_R_EN_IN | MEM_W_EN_IN;
        return (m_pos == 0 && !req) || (m_pos == DonePos);
    endfunction

    // Compare every DUT output against the model (called mid-cycle)
    task automatic check_now();
        logic        hi;
        logic [31:0] exp_addr;
        chk("ready", 32'(ready), 32'(model_ready()));
        if (!ready) low_cnt++;
        chk("WB_EN", 32'(WB_EN), 32'(m_wb));
        chk("MEM_R_EN", 32'(MEM_R_EN), 32'(m_mr));
        chk("ALU_result", ALU_result, m_alu);
        chk("Dest", 32'(Dest), 32'(m_dest));
        chk("Mem_read_value", Mem_read_value, m_mrv);
        if (m_pos >= 1 && m_pos <= 2 * Phase) begin
            hi       = (m_pos > Phase);
            exp_addr = 32'(word_idx(ALU_result_IN) * 2) + 32'(hi);
            chk("SRAM_ADDR", 32'(SRAM_ADDR), exp_addr);
            if (MEM_W_EN_IN) begin
                chk("SRAM_WE_N st", 32'(SRAM_WE_N), 32'(0));
                chk("SRAM_DQ_OE st", 32'(SRAM_DQ_OE), 32'(1));
                chk("SRAM_DQ_O", 32'(SRAM_DQ_O), hi ? 32'(ST_val_IN[31:16]) : 32'(ST_val_IN[15:0]));
            end else begin
                chk("SRAM_WE_N ld", 32'(SRAM_WE_N), 32'(1));
                chk("SRAM_DQ_OE ld", 32'(SRAM_DQ_OE), 32'(0));
            end
        end else begin
            chk("SRAM_WE_N idle", 32'(SRAM_WE_N), 32'(1));
            chk("SRAM_DQ_OE idle", 32'(SRAM_DQ_OE), 32'(0));
        end
`ifdef MEM_ADDR_CHECK_EN
        chk("mem_err", 32'(mem_err), 32'(m_pos == DonePos && m_bad));
`endif
        // The SRAM latches whatever the strobe presents
        if (!SRAM_WE_N) sram[SRAM_ADDR[9:0]] = SRAM_DQ_O;
    endtask

    // Advance the model across a rising edge, using the inputs that were presented to it
    task automatic update();
        int wi;
        wi = word_idx(ALU_result_IN);
        if (model_ready()) begin
            m_wb   = WB_EN_IN;
            m_mr   = MEM_R_EN_IN;
            m_alu  = ALU_result_IN;
            m_dest = Dest_IN;
            m_mrv  = m_rdata;
        end else begin
            m_wb = 1'b0;
        end
        if (m_pos == 0) begin
            if (MEM_R_EN_IN | MEM_W_EN_IN) begin
                m_bad = addr_bad(ALU_result_IN);
                m_pos = m_bad ? DonePos : 1;
                if (m_bad && !MEM_W_EN_IN) m_rdata = '0;
            end
        end else if (m_pos < DonePos) begin
            if (m_pos == 2 * Phase) begin
                if (MEM_W_EN_IN) begin
                    ref_mem[2*wi]   = ST_val_IN[15:0];
                    ref_mem[2*wi+1] = ST_val_IN[31:16];
                end else begin
                    m_rdata = {ref_mem[2*wi+1], ref_mem[2*wi]};
                end
            end
            m_pos++;
        end else begin
            m_pos = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_now();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic model_reset();
        m_pos = 0; m_bad = 1'b0; m_wb = 1'b0; m_mr = 1'b0;
        m_alu = '0; m_mrv = '0; m_rdata = '0; m_dest = '0;
    endtask

    task automatic set_in(input logic wb, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] st, input logic [3:0] d);
        WB_EN_IN = wb; MEM_R_EN_IN = rd; MEM_W_EN_IN = wr;
        ALU_result_IN = a; ST_val_IN = st; Dest_IN = d;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = 16'(i * 37 + 5);
            ref_mem[i] = 16'(i * 37 + 5);
        end
        model_reset();
        rst = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd9);

        // Reset held with WB_EN_IN high: outputs cleared
        #22;
        chk("rst WB_EN", 32'(WB_EN), 32'(0));
        chk("rst MEM_R_EN", 32'(MEM_R_EN), 32'(0));
        chk("rst ALU_result", ALU_result, 32'h0);
        chk("rst Mem_read_value", Mem_read_value, 32'h0);
        chk("rst Dest", 32'(Dest), 32'(0));
        chk("rst SRAM_ADDR", 32'(SRAM_ADDR), 32'h0);
        chk("rst SRAM_DQ_O", 32'(SRAM_DQ_O), 32'h0);
        chk("rst SRAM_DQ_OE", 32'(SRAM_DQ_OE), 32'(0));
        chk("rst SRAM_WE_N", 32'(SRAM_WE_N), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        update();
        #1;

        // Non-memory op passes straight through
        low_cnt = 0;
        set_in(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
        cycle();
        chk("nonmem ALU_result", ALU_result, 32'h55);
        chk("nonmem Dest", 32'(Dest), 32'(3));
        chk("nonmem WB_EN", 32'(WB_EN), 32'(1));
        set_in(1'b1, 1'b0, 1'b0, 32'hA0, 32'h0, 4'd7);
        repeat (2) cycle();
        chk("nonmem never stalls", 32'(low_cnt), 32'(0));

        // Store 0xDEADBEEF to 1028
        low_cnt = 0;
        set_in(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0);
        repeat (AccLen) cycle();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk("store stall cycles", 32'(low_cnt), 32'd7);
        chk("store WB_EN", 32'(WB_EN), 32'(0));
        chk("store sram[2]", 32'(sram[2]), 32'hBEEF);
        chk("store sram[3]", 32'(sram[3]), 32'hDEAD);
        cycle();

        // Load back from 1028
        low_cnt = 0;
        set_in(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5);
        repeat (AccLen) cycle();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk("load stall cycles", 32'(low_cnt), 32'd7);
        chk("load value", Mem_read_value, 32'hDEADBEEF);
        chk("load MEM_R_EN", 32'(MEM_R_EN), 32'(1));
        chk("load WB_EN", 32'(WB_EN), 32'(1));
        cycle();
        chk("load WB_EN one cycle", 32'(WB_EN), 32'(0));

        // Back-to-back store then load at 1032
        low_cnt = 0;
        set_in(1'b0, 1'b0, 1'b1, 32'd1032, 32'h12345678, 4'd0);
        repeat (AccLen) cycle();
        set_in(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd6);
        repeat (AccLen) cycle();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk("b2b stall cycles", 32'(low_cnt), 32'd14);
        chk("b2b load value", Mem_read_value, 32'h12345678);
        chk("b2b Dest", 32'(Dest), 32'(6));
        cycle();

        // Reset during the second HI cycle of a store
        set_in(1'b0, 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 4'd0);
        repeat (5) cycle();
        chk("pre-rst SRAM_WE_N", 32'(SRAM_WE_N), 32'(0));
        chk("pre-rst SRAM_ADDR", 32'(SRAM_ADDR), 32'd9);
        #2;
        rst = 1'b0;
        #1;
        chk("mid-rst SRAM_WE_N", 32'(SRAM_WE_N), 32'(1));
        chk("mid-rst FSM idle", 32'(u_dut.u_ctrl.state_q), 32'(StIdle));
        chk("mid-rst WB_EN", 32'(WB_EN), 32'(0));
        chk("mid-rst ready", 32'(ready), 32'(0));
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        update();
        #1;
        repeat (2) cycle();

        // Recovery: load 1028 again
        set_in(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd2);
        repeat (AccLen) cycle();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk("post-rst load", Mem_read_value, 32'hDEADBEEF);
        cycle();

`ifdef MEM_ADDR_CHECK_EN
        // Misaligned load is rejected without touching the SRAM
        low_cnt = 0;
        set_in(1'b1, 1'b1, 1'b0, 32'd1026, 32'h0, 4'd4);
        cycle();
        chk("err mem_err in DONE", 32'(mem_err), 32'(1));
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk("err stall cycles", 32'(low_cnt), 32'd1);
        chk("err load value", Mem_read_value, 32'h0);
        cycle();
        chk("err mem_err cleared", 32'(mem_err), 32'(0));
`endif

        repeat (2) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
